// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the control bundle.
package decode_pkg;

  localparam logic [6:0] OP_R         = 7'b0110011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  // One-hot immediate format
  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  typedef struct packed {
    logic [5:0] fmt;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic       is_system;
    logic       imm_alu;
    logic       reg_write;
    logic [2:0] alu_opsel;
    logic       alu_sub;
    logic       alu_arith;
    logic       mem_word;
    logic       mem_half;
    logic       mem_unsigned;
  } decode_ctrl_t;

  localparam int unsigned CTRL_W = $bits(decode_ctrl_t);

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I instruction decoder: control bundle, immediate and operand usage.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [31:0]  instr,
  output decode_ctrl_t ctrl,
  output logic [31:0]  imm,
  output logic         illegal,
  output logic         is_load,
  output logic         uses_rs1,
  output logic         uses_rs2
);

  logic [2:0] funct3;
  logic       fmt_r, fmt_s, fmt_b, fmt_u, fmt_j;

  always_comb begin
    ctrl    = '0;
    imm     = '0;
    illegal = 1'b0;
    funct3  = instr[14:12];

    case (instr[6:0])
      OP_R:         ctrl.fmt = FMT_R;
      OP_IMM_ARITH: ctrl.fmt = FMT_I;
      OP_LOAD:      begin ctrl.fmt = FMT_I; ctrl.is_load   = 1'b1; end
      OP_STORE:     begin ctrl.fmt = FMT_S; ctrl.is_store  = 1'b1; end
      OP_BRANCH:    begin ctrl.fmt = FMT_B; ctrl.is_branch = 1'b1; end
      OP_JAL:       begin ctrl.fmt = FMT_J; ctrl.is_jal    = 1'b1; end
      OP_JALR:      begin ctrl.fmt = FMT_I; ctrl.is_jalr   = 1'b1; end
      OP_LUI:       begin ctrl.fmt = FMT_U; ctrl.is_lui    = 1'b1; end
      OP_AUIPC:     begin ctrl.fmt = FMT_U; ctrl.is_auipc  = 1'b1; end
      OP_SYSTEM:    begin ctrl.fmt = FMT_I; ctrl.is_system = 1'b1; end
      default:      illegal = 1'b1;
    endcase

    fmt_r = (ctrl.fmt == FMT_R);
    fmt_s = (ctrl.fmt == FMT_S);
    fmt_b = (ctrl.fmt == FMT_B);
    fmt_u = (ctrl.fmt == FMT_U);
    fmt_j = (ctrl.fmt == FMT_J);

    ctrl.imm_alu      = !(fmt_r || fmt_b);
    ctrl.reg_write    = !(fmt_s || fmt_b);
    ctrl.alu_opsel    = (fmt_r || instr[6:0] == OP_IMM_ARITH) ? funct3 : 3'b000;
    ctrl.alu_sub      = fmt_r & instr[30];
    ctrl.alu_arith    = instr[30];
    ctrl.mem_word     = funct3[1];
    ctrl.mem_half     = funct3[0];
    ctrl.mem_unsigned = ctrl.is_load & funct3[2];

    // Sign-extended immediate per format
    case (ctrl.fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase

    is_load  = ctrl.is_load;
    uses_rs1 = !illegal && !(fmt_u || fmt_j);
    uses_rs2 = fmt_r || fmt_s || fmt_b;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction queue, load-use interlock, trap/halt and registered output slot.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned XLEN           = 32,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output decode_ctrl_t    o_ctrl,
  output logic [31:0]     o_imm,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic            o_trap,
  output logic            o_halted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             halt_seen;
  logic             pend_vld;
  logic [4:0]       pend_rd;

  logic [31:0]      head_instr;
  logic [XLEN-1:0]  head_pc;
  logic [4:0]       head_rs1, head_rs2, head_rd;

  decode_ctrl_t     dec_ctrl;
  logic [31:0]      dec_imm;
  logic             dec_illegal, dec_load, dec_rs1, dec_rs2;

  logic             empty, full, slot_free, hazard, can_take, issue, enq, deq;

  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];
  assign head_rs1   = head_instr[19:15];
  assign head_rs2   = head_instr[24:20];
  assign head_rd    = head_instr[11:7];

  decode_ctrl u_decode_ctrl (
    .instr    (head_instr),
    .ctrl     (dec_ctrl),
    .imm      (dec_imm),
    .illegal  (dec_illegal),
    .is_load  (dec_load),
    .uses_rs1 (dec_rs1),
    .uses_rs2 (dec_rs2)
  );

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign o_ready   = !full && !halt_seen && !o_trap;
  assign slot_free = !o_valid || i_ready;

  // x0 never becomes pending, so x0 consumers never match
  assign hazard    = LOAD_USE_STALL && pend_vld &&
                     ((dec_rs1 && head_rs1 == pend_rd) || (dec_rs2 && head_rs2 == pend_rd));
  assign can_take  = !empty && slot_free && !dec_illegal && !o_trap && !halt_seen;
  assign issue     = can_take && !hazard;
  assign enq       = i_valid && o_ready && !i_flush;
  assign deq       = issue && !i_flush;

  // Queue storage carries no reset; validity is tracked by count
  always_ff @(posedge i_clk) begin
    if (enq) begin
      instr_q[wr_ptr] <= i_instr;
      pc_q[wr_ptr]    <= i_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Hazard tracking, sticky trap and halt
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pend_vld  <= 1'b0;
      pend_rd   <= '0;
      o_trap    <= 1'b0;
      halt_seen <= 1'b0;
      o_halted  <= 1'b0;
    end else if (i_flush) begin
      pend_vld  <= 1'b0;
      o_trap    <= 1'b0;
    end else begin
      if (can_take) begin
        pend_vld <= LOAD_USE_STALL && issue && dec_load && (head_rd != 5'd0);
        pend_rd  <= head_rd;
      end
      if (!empty && dec_illegal && !halt_seen) o_trap <= 1'b1;
      if (issue && dec_ctrl.is_system) halt_seen <= 1'b1;
      if (o_valid && i_ready && o_ctrl.is_system) o_halted <= 1'b1;
    end
  end

  // Output slot: loads on issue, empties on accept, otherwise holds
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid    <= 1'b0;
      o_ctrl     <= '0;
      o_imm      <= '0;
      o_pc       <= '0;
      o_pc_plus4 <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
      o_rd       <= '0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
    end else if (issue) begin
      o_valid    <= 1'b1;
      o_ctrl     <= dec_ctrl;
      o_imm      <= dec_imm;
      o_pc       <= head_pc;
      o_pc_plus4 <= head_pc + XLEN'(4);
      o_rs1      <= head_rs1;
      o_rs2      <= head_rs2;
      o_rd       <= head_rd;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; a second instance runs without the load-use interlock.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [31:0] ADDI_X1_5 = 32'h00500093;
  localparam logic [31:0] ADDI_NEG  = 32'hFFF00293;
  localparam logic [31:0] LW_X2     = 32'h0000A103;
  localparam logic [31:0] ADD_HAZ   = 32'h001101B3;
  localparam logic [31:0] ADD_X0    = 32'h001001B3;
  localparam logic [31:0] SW_X2     = 32'h0020A423;
  localparam logic [31:0] ECALL     = 32'h00000073;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  instr;
  logic [31:0]  pc;
  logic         flush;
  logic         out_ready;

  logic         a_ready, a_valid, a_trap, a_halted;
  decode_ctrl_t a_ctrl;
  logic [31:0]  a_imm, a_pc, a_pc4;
  logic [4:0]   a_rs1, a_rs2, a_rd;

  logic         b_ready, b_valid, b_trap, b_halted;
  decode_ctrl_t b_ctrl;
  logic [31:0]  b_imm, b_pc, b_pc4;
  logic [4:0]   b_rs1, b_rs2, b_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(4), .XLEN(32), .LOAD_USE_STALL(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(in_valid), .o_ready(a_ready),
    .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_valid(a_valid),
    .i_ready(out_ready), .o_ctrl(a_ctrl), .o_imm(a_imm), .o_pc(a_pc),
    .o_pc_plus4(a_pc4), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_rd(a_rd),
    .o_trap(a_trap), .o_halted(a_halted)
  );

  decode_stage #(.DEPTH(4), .XLEN(32), .LOAD_USE_STALL(1'b0)) u_dut_nostall (
    .i_clk(clk), .i_rst(rst_n), .i_valid(in_valid), .o_ready(b_ready),
    .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_valid(b_valid),
    .i_ready(out_ready), .o_ctrl(b_ctrl), .o_imm(b_imm), .o_pc(b_pc),
    .o_pc_plus4(b_pc4), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd),
    .o_trap(b_trap), .o_halted(b_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Enqueue one instruction; on return it sits in the output slot when i_ready=1
  task automatic issue_one(input logic [31:0] ins, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = ins;
    pc       = p;
    step();
    in_valid = 1'b0;
    check("latency_gap", 32'(a_valid), 32'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    step();
    do_reset();

    // Reset state of both instances
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_trap", 32'(a_trap), 32'd0);
    check("rst_halted", 32'(a_halted), 32'd0);
    check("rst_ctrl", 32'(a_ctrl), 32'd0);
    check("rst_pc", a_pc, 32'd0);
    check("b_rst_flags", 32'({b_ready, b_valid, b_trap, b_halted}), 32'b1000);
    check("b_rst_fields", 32'({b_ctrl, b_rs1, b_rs2, b_rd}), 32'd0);
    check("b_rst_words", b_imm | b_pc | b_pc4, 32'd0);

    // addi x1,x0,5
    issue_one(ADDI_X1_5, 32'h0000_1000);
    check("addi_valid", 32'(a_valid), 32'd1);
    check("addi_rd", 32'(a_rd), 32'd1);
    check("addi_imm", a_imm, 32'd5);
    check("addi_imm_alu", 32'(a_ctrl.imm_alu), 32'd1);
    check("addi_reg_write", 32'(a_ctrl.reg_write), 32'd1);
    check("addi_opsel", 32'(a_ctrl.alu_opsel), 32'd0);
    check("addi_pc", a_pc, 32'h0000_1000);
    check("addi_pc4", a_pc4, 32'h0000_1004);
    step();
    check("addi_drained", 32'(a_valid), 32'd0);

    // Negative immediate and PC wrap-around
    issue_one(ADDI_NEG, 32'hFFFF_FFFC);
    check("neg_imm", a_imm, 32'hFFFF_FFFF);
    check("neg_rd", 32'(a_rd), 32'd5);
    check("pc4_wrap", a_pc4, 32'h0000_0000);
    step();

    // Store: S immediate, no register write
    issue_one(SW_X2, 32'h0000_1100);
    check("sw_imm", a_imm, 32'd8);
    check("sw_rs1", 32'(a_rs1), 32'd1);
    check("sw_rs2", 32'(a_rs2), 32'd2);
    check("sw_reg_write", 32'(a_ctrl.reg_write), 32'd0);
    check("sw_store", 32'(a_ctrl.is_store), 32'd1);
    step();

    // Load-use: lw x2 then add x3,x2,x1
    in_valid = 1'b1; instr = LW_X2; pc = 32'h0000_2000;
    step();
    instr = ADD_HAZ; pc = 32'h0000_2004;
    step();
    in_valid = 1'b0;
    check("lw_valid", 32'(a_valid), 32'd1);
    check("lw_pc", a_pc, 32'h0000_2000);
    check("lw_is_load", 32'(a_ctrl.is_load), 32'd1);
    check("lw_word", 32'(a_ctrl.mem_word), 32'd1);
    check("lw_rd", 32'(a_rd), 32'd2);
    check("b_lw_pc", b_pc, 32'h0000_2000);
    step();
    check("lu_bubble", 32'(a_valid), 32'd0);
    check("b_nobubble", 32'(b_valid), 32'd1);
    check("b_add_pc", b_pc, 32'h0000_2004);
    step();
    check("lu_add_valid", 32'(a_valid), 32'd1);
    check("lu_add_pc", a_pc, 32'h0000_2004);
    check("lu_add_imm_alu", 32'(a_ctrl.imm_alu), 32'd0);
    check("b_after", 32'(b_valid), 32'd0);
    step();

    // Load followed by x0/x1 consumer: no bubble in either instance
    in_valid = 1'b1; instr = LW_X2; pc = 32'h0000_2100;
    step();
    instr = ADD_X0; pc = 32'h0000_2104;
    step();
    in_valid = 1'b0;
    step();
    check("x0_nobubble", 32'(a_valid), 32'd1);
    check("x0_pc", a_pc, 32'h0000_2104);
    check("b_x0_pc", b_pc, 32'h0000_2104);
    step();

    // Fill with i_ready=0: slot plus four entries accept, sixth refused
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fill_ready%0d", k), 32'(a_ready), (k < 5) ? 32'd1 : 32'd0);
      in_valid = 1'b1;
      instr    = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
      pc       = 32'h0000_3000 + 32'(4 * k);
      step();
    end
    in_valid = 1'b0;
    check("fill_head_pc", a_pc, 32'h0000_3000);
    check("fill_hold_rd", 32'(a_rd), 32'd1);
    out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      check($sformatf("drain_pc%0d", j), a_pc, 32'h0000_3000 + 32'(4 * j));
      check($sformatf("drain_imm%0d", j), a_imm, 32'(j));
    end
    step();
    check("drain_empty", 32'(a_valid), 32'd0);
    issue_one(ADDI_X1_5, 32'h0000_3100);
    check("wrap_pc", a_pc, 32'h0000_3100);
    step();

    // Illegal opcode traps until flush
    in_valid = 1'b1; instr = 32'h0000_0000; pc = 32'h0000_4000;
    step();
    in_valid = 1'b0;
    step();
    check("trap_set", 32'(a_trap), 32'd1);
    check("trap_ready", 32'(a_ready), 32'd0);
    check("trap_no_issue", 32'(a_valid), 32'd0);
    step();
    check("trap_hold", 32'(a_trap), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_trap", 32'(a_trap), 32'd0);
    check("flush_valid", 32'(a_valid), 32'd0);
    check("flush_ready", 32'(a_ready), 32'd1);
    step();
    check("flush_empty", 32'({a_valid, a_trap}), 32'd0);
    issue_one(ADDI_X1_5, 32'h0000_4100);
    check("post_flush_pc", a_pc, 32'h0000_4100);
    step();

    // Enqueue in flush cycle is dropped
    in_valid = 1'b1; flush = 1'b1; instr = ADDI_X1_5; pc = 32'h0000_4200;
    step();
    in_valid = 1'b0; flush = 1'b0;
    step();
    check("flush_drop", 32'(a_valid), 32'd0);
    step();
    check("flush_drop2", 32'(a_valid), 32'd0);

    // Halt: ecall issues, following addi never does
    in_valid = 1'b1; instr = ECALL; pc = 32'h0000_5000;
    step();
    instr = ADDI_X1_5; pc = 32'h0000_5004;
    step();
    in_valid = 1'b0;
    check("ecall_valid", 32'(a_valid), 32'd1);
    check("ecall_pc", a_pc, 32'h0000_5000);
    check("ecall_system", 32'(a_ctrl.is_system), 32'd1);
    check("ecall_not_halted", 32'(a_halted), 32'd0);
    check("ecall_ready", 32'(a_ready), 32'd0);
    step();
    check("halted", 32'(a_halted), 32'd1);
    check("halt_no_issue", 32'(a_valid), 32'd0);
    for (int j = 0; j < 4; j++) step();
    check("halt_stays", 32'({a_valid, a_ready, a_halted}), 32'b001);

    // Asynchronous reset while the slot is stalled
    do_reset();
    check("reset_clears_halt", 32'(a_halted), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; instr = ADDI_X1_5; pc = 32'h0000_6000;
    step();
    in_valid = 1'b0;
    step();
    check("stall_valid", 32'(a_valid), 32'd1);
    step();
    check("stall_hold_pc", a_pc, 32'h0000_6000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_valid), 32'd0);
    check("arst_fields", 32'({a_ctrl, a_rd, a_rs1}), 32'd0);
    check("arst_words", a_imm | a_pc | a_pc4, 32'd0);
    check("arst_flags", 32'({a_trap, a_halted}), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_empty", 32'(a_valid), 32'd0);
    issue_one(ADDI_X1_5, 32'h0000_6100);
    check("post_rst_pc", a_pc, 32'h0000_6100);
    check("post_rst_rd", 32'(a_rd), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
